pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It replaces the fixed 5-stage hazard and forwarding pair with a single block for a configurable stage count, branch-resolve stage and load-data stage. The block keeps its own shadow pipeline of destination and valid tracking. From that it drives PC hold, per-register stall/flush, PC source and source-operand forwarding selects, and it keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for an in-order pipeline of configurable depth.
// Tracks in-flight destinations in a shadow pipeline and drives stall/flush/forward decisions.
module pipe_hazard_ctrl #(
   parameter int NSTAGE   = 5,
   parameter int REG_W    = 5,
   parameter int BR_STAGE = 3,
   parameter int LD_STAGE = 3,
   parameter int SELW     = $clog2(NSTAGE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_hold,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_rs_rd,
   input  logic              id_rt_rd,
   input  logic [REG_W-1:0]  id_dst,
   input  logic              id_wen,
   input  logic              id_load,
   input  logic              ex_jump,
   input  logic              br_take,
   output logic              pc_stall,
   output logic [NSTAGE-2:0] stall,
   output logic [NSTAGE-2:0] flush,
   output logic [1:0]        pc_src,
   output logic [SELW-1:0]   fwd_rs_sel,
   output logic [SELW-1:0]   fwd_rt_sel,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   logic [NSTAGE-1:2] vld_q, vld_d;
   logic [NSTAGE-1:2] wen_q, wen_d;
   logic [NSTAGE-1:2] ld_q, ld_d;
   logic [REG_W-1:0]  dst_q [2:NSTAGE-1];
   logic [REG_W-1:0]  dst_d [2:NSTAGE-1];
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic [31:0]       flush_cnt_q, flush_cnt_d;

   logic [SELW-1:0]   rs_sel, rt_sel;
   logic              rs_lu, rt_lu, load_use;
   logic              stall_inc, flush_inc;

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      rs_sel = '0;
      rt_sel = '0;
      rs_lu  = 1'b0;
      rt_lu  = 1'b0;
      for (int k = NSTAGE-1; k >= 2; k--) begin
         if (id_rs_rd && id_rs != '0 && vld_q[k] && wen_q[k] && dst_q[k] == id_rs) begin
            rs_sel = SELW'(k);
            rs_lu  = ld_q[k] && (k <= LD_STAGE);
         end
         if (id_rt_rd && id_rt != '0 && vld_q[k] && wen_q[k] && dst_q[k] == id_rt) begin
            rt_sel = SELW'(k);
            rt_lu  = ld_q[k] && (k <= LD_STAGE);
         end
      end
      load_use = id_valid && (rs_lu || rt_lu);
   end

   assign fwd_rs_sel = rs_sel;
   assign fwd_rt_sel = rt_sel;

   always_comb begin
      pc_stall  = 1'b0;
      stall     = '0;
      flush     = '0;
      pc_src    = 2'b00;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (ext_hold) begin
         stall     = '1;
         pc_stall  = 1'b1;
         stall_inc = 1'b1;
      end else if (br_take) begin
         pc_src    = 2'b10;
         flush_inc = 1'b1;
         for (int k = 0; k < NSTAGE-1; k++) begin
            if (k < BR_STAGE) flush[k] = 1'b1;
         end
      end else if (ex_jump) begin
         pc_src    = 2'b01;
         flush[1:0] = 2'b11;
         flush_inc = 1'b1;
      end else if (load_use) begin
         pc_stall  = 1'b1;
         stall[0]  = 1'b1;
         flush[1]  = 1'b1;
         stall_inc = 1'b1;
      end
   end

   // A flushed pipeline register turns the shadow entry behind it into a bubble.
   always_comb begin
      vld_d = vld_q;
      wen_d = wen_q;
      ld_d  = ld_q;
      dst_d = dst_q;
      if (!ext_hold) begin
         vld_d[2] = id_valid & ~flush[1];
         wen_d[2] = id_wen;
         ld_d[2]  = id_load;
         dst_d[2] = id_dst;
         for (int k = 3; k < NSTAGE; k++) begin
            vld_d[k] = vld_q[k-1] & ~flush[k-1];
            wen_d[k] = wen_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dst_d[k] = dst_q[k-1];
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         vld_q       <= vld_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      wen_q <= wen_d;
      ld_q  <= ld_d;
      dst_q <= dst_d;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default 5-stage build plus a 7-stage build.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, ext_hold, id_valid, id_rs_rd, id_rt_rd, id_wen, id_load, ex_jump, br_take;
   logic [4:0] id_rs, id_rt, id_dst;

   logic       pc_stall;
   logic [3:0] stall, flush;
   logic [1:0] pc_src;
   logic [2:0] fwd_rs_sel, fwd_rt_sel;
   logic [31:0] stall_cnt, flush_cnt;

   logic       pc_stall7;
   logic [5:0] stall7, flush7;
   logic [1:0] pc_src7;
   logic [2:0] fwd_rs_sel7, fwd_rt_sel7;
   logic [31:0] stall_cnt7, flush_cnt7;

   int checks = 0;
   int failures = 0;

   pipe_hazard_ctrl #(.NSTAGE(5), .REG_W(5), .BR_STAGE(3), .LD_STAGE(3)) u5 (
      .clk(clk), .rst_n(rst_n), .ext_hold(ext_hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd),
      .id_dst(id_dst), .id_wen(id_wen), .id_load(id_load), .ex_jump(ex_jump),
      .br_take(br_take), .pc_stall(pc_stall), .stall(stall), .flush(flush),
      .pc_src(pc_src), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.NSTAGE(7), .REG_W(5), .BR_STAGE(5), .LD_STAGE(4)) u7 (
      .clk(clk), .rst_n(rst_n), .ext_hold(ext_hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd),
      .id_dst(id_dst), .id_wen(id_wen), .id_load(id_load), .ex_jump(ex_jump),
      .br_take(br_take), .pc_stall(pc_stall7), .stall(stall7), .flush(flush7),
      .pc_src(pc_src7), .fwd_rs_sel(fwd_rs_sel7), .fwd_rt_sel(fwd_rt_sel7),
      .stall_cnt(stall_cnt7), .flush_cnt(flush_cnt7)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ext_hold = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0;
      id_rs_rd = 1'b0; id_rt_rd = 1'b0; id_dst = '0; id_wen = 1'b0;
      id_load = 1'b0; ex_jump = 1'b0; br_take = 1'b0;
   endtask

   task automatic issue(input logic [4:0] dst, input logic wen, input logic ld);
      idle();
      id_valid = 1'b1; id_dst = dst; id_wen = wen; id_load = ld;
   endtask

   task automatic reader(input logic [4:0] rs, input logic rsr, input logic [4:0] rt, input logic rtr);
      idle();
      id_valid = 1'b1; id_rs = rs; id_rs_rd = rsr; id_rt = rt; id_rt_rd = rtr;
   endtask

   initial begin
      // reset with every input high
      rst_n = 1'b0; ext_hold = 1'b1; id_valid = 1'b1; id_rs = 5'h1f; id_rt = 5'h1f;
      id_rs_rd = 1'b1; id_rt_rd = 1'b1; id_dst = 5'h1f; id_wen = 1'b1; id_load = 1'b1;
      ex_jump = 1'b1; br_take = 1'b1;
      tick();
      rst_n = 1'b1; idle(); #2;
      chk("rst_stall", stall, 4'b0000);
      chk("rst_flush", flush, 4'b0000);
      chk("rst_pc_src", pc_src, 2'b00);
      chk("rst_pc_stall", pc_stall, 1'b0);
      chk("rst_fwd_rs", fwd_rs_sel, 3'd0);
      chk("rst_fwd_rt", fwd_rt_sel, 3'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);

      // ALU producer forwarding walks through stages 2,3,4 then retires
      issue(5'd3, 1'b1, 1'b0); tick();
      reader(5'd3, 1'b1, 5'd0, 1'b0); #2;
      chk("fwd_alu_k2", fwd_rs_sel, 3'd2);
      chk("fwd_alu_nostall", pc_stall, 1'b0);
      tick(); #2;
      chk("fwd_alu_k3", fwd_rs_sel, 3'd3);
      tick(); #2;
      chk("fwd_alu_k4", fwd_rs_sel, 3'd4);
      tick(); #2;
      chk("fwd_alu_gone", fwd_rs_sel, 3'd0);
      tick();

      // load in stage 3 when the reader arrives: one stall cycle
      issue(5'd5, 1'b1, 1'b1); tick();
      issue(5'd0, 1'b0, 1'b0); tick();
      reader(5'd0, 1'b0, 5'd5, 1'b1); #2;
      chk("lu1_pc_stall", pc_stall, 1'b1);
      chk("lu1_stall", stall, 4'b0001);
      chk("lu1_flush", flush, 4'b0010);
      chk("lu1_sel", fwd_rt_sel, 3'd3);
      tick(); #2;
      chk("lu1_release", pc_stall, 1'b0);
      chk("lu1_fwd4", fwd_rt_sel, 3'd4);
      chk("lu1_stall_after", stall, 4'b0000);
      chk("lu1_stall_cnt", stall_cnt, 32'd1);
      tick();

      // load directly ahead in EX: LD_STAGE-2+1 = 2 stall cycles
      issue(5'd6, 1'b1, 1'b1); tick();
      reader(5'd6, 1'b1, 5'd0, 1'b0); #2;
      chk("lu2_c1", pc_stall, 1'b1);
      chk("lu2_c1_sel", fwd_rs_sel, 3'd2);
      tick(); #2;
      chk("lu2_c2", pc_stall, 1'b1);
      chk("lu2_c2_sel", fwd_rs_sel, 3'd3);
      tick(); #2;
      chk("lu2_done", pc_stall, 1'b0);
      chk("lu2_fwd4", fwd_rs_sel, 3'd4);
      chk("lu2_stall_cnt", stall_cnt, 32'd3);
      tick();

      // taken branch overrides load-use and invalidates flushed entries
      issue(5'd7, 1'b1, 1'b1); tick();
      reader(5'd7, 1'b1, 5'd0, 1'b0); br_take = 1'b1; #2;
      chk("br_flush", flush, 4'b0111);
      chk("br_pc_src", pc_src, 2'b10);
      chk("br_pc_stall", pc_stall, 1'b0);
      chk("br_stall", stall, 4'b0000);
      tick();
      reader(5'd7, 1'b1, 5'd0, 1'b0); #2;
      chk("br_flush_cnt", flush_cnt, 32'd1);
      chk("br_no_stall_cnt", stall_cnt, 32'd3);
      chk("br_killed_fwd", fwd_rs_sel, 3'd0);
      chk("br_killed_stall", pc_stall, 1'b0);
      tick();

      // external hold with a pending branch freezes the shadow
      issue(5'd9, 1'b1, 1'b0); tick();
      for (int i = 0; i < 3; i++) begin
         reader(5'd9, 1'b1, 5'd0, 1'b0); ext_hold = 1'b1; br_take = 1'b1; #2;
         chk("hold_stall", stall, 4'b1111);
         chk("hold_flush", flush, 4'b0000);
         chk("hold_pc_src", pc_src, 2'b00);
         chk("hold_frozen_fwd", fwd_rs_sel, 3'd2);
         tick();
      end
      reader(5'd9, 1'b1, 5'd0, 1'b0); br_take = 1'b1; #2;
      chk("hold_stall_cnt", stall_cnt, 32'd6);
      chk("hold_rel_flush", flush, 4'b0111);
      chk("hold_rel_pc_src", pc_src, 2'b10);
      tick();
      idle(); #2;
      chk("hold_rel_flush_cnt", flush_cnt, 32'd2);

      // load to $0 never forwards or stalls
      issue(5'd0, 1'b1, 1'b1); tick();
      reader(5'd0, 1'b1, 5'd0, 1'b1); #2;
      chk("r0_fwd_rs", fwd_rs_sel, 3'd0);
      chk("r0_fwd_rt", fwd_rt_sel, 3'd0);
      chk("r0_no_stall", pc_stall, 1'b0);
      tick();

      // an invalid ID slot never stalls
      issue(5'd8, 1'b1, 1'b1); tick();
      reader(5'd8, 1'b1, 5'd0, 1'b0); id_valid = 1'b0; #2;
      chk("inv_no_stall", pc_stall, 1'b0);
      chk("inv_stall_bits", stall, 4'b0000);
      tick();

      // jump overrides load-use
      issue(5'd12, 1'b1, 1'b1); tick();
      reader(5'd12, 1'b1, 5'd0, 1'b0); ex_jump = 1'b1; #2;
      chk("jmp_flush", flush, 4'b0011);
      chk("jmp_pc_src", pc_src, 2'b01);
      chk("jmp_pc_stall", pc_stall, 1'b0);
      tick();
      idle(); #2;
      chk("jmp_flush_cnt", flush_cnt, 32'd3);
      chk("jmp_stall_cnt", stall_cnt, 32'd6);

      // mid-run reset drops in-flight producers
      issue(5'd10, 1'b1, 1'b0); tick();
      idle(); rst_n = 1'b0; tick();
      rst_n = 1'b1;
      reader(5'd10, 1'b1, 5'd0, 1'b0); #2;
      chk("mrst_fwd5", fwd_rs_sel, 3'd0);
      chk("mrst_fwd7", fwd_rs_sel7, 3'd0);
      chk("mrst_cnt", stall_cnt, 32'd0);
      tick();

      // 7-stage build: branch flush and 3-cycle load-use
      idle(); br_take = 1'b1; #2;
      chk("n7_br_flush", flush7, 6'b011111);
      chk("n7_br_pc_src", pc_src7, 2'b10);
      tick();
      issue(5'd11, 1'b1, 1'b1); tick();
      reader(5'd0, 1'b0, 5'd11, 1'b1); #2;
      chk("n7_lu_c1", pc_stall7, 1'b1);
      chk("n7_lu_c1_stall", stall7, 6'b000001);
      tick(); #2;
      chk("n7_lu_c2", pc_stall7, 1'b1);
      tick(); #2;
      chk("n7_lu_c3", pc_stall7, 1'b1);
      chk("n7_lu_c3_sel", fwd_rt_sel7, 3'd4);
      tick(); #2;
      chk("n7_lu_done", pc_stall7, 1'b0);
      chk("n7_fwd5", fwd_rt_sel7, 3'd5);
      chk("n7_stall_cnt", stall_cnt7, 32'd3);
      chk("n7_flush_cnt", flush_cnt7, 32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
